// File: rtl/calendar_pkg.sv
// Shared encodings for the calendar set controller: state/field codes and default limits.
package calendar_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        SET_DAY   = 2'b01,
        SET_MONTH = 2'b10,
        SET_YEAR  = 2'b11
    } cal_state_e;

    localparam int TIMEOUT_TICKS_DEFAULT = 10;
    localparam int MAX_PENDING_DEFAULT   = 7;

    function automatic cal_state_e next_field(input cal_state_e cur);
        cal_state_e nxt;
        case (cur)
            RUN:       nxt = SET_DAY;
            SET_DAY:   nxt = SET_MONTH;
            SET_MONTH: nxt = SET_YEAR;
            SET_YEAR:  nxt = RUN;
            default:   nxt = RUN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector; the rise output is high for exactly one clk per 0->1 input change.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_q_r;

    // Delayed copy of the input for edge comparison
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q_r <= 1'b0;
        end else begin
            sig_q_r <= sig;
        end
    end

    assign rise = sig & ~sig_q_r;

endmodule

// File: rtl/calendar_set_ctrl.sv
// Button-driven calendar set controller: walks RUN/day/month/year, queues up-presses and
// releases them to the calendar as inc_* requests, one per tick_1Hz rise.
module calendar_set_ctrl
    import calendar_pkg::*;
#(
    parameter int MAX_PENDING   = MAX_PENDING_DEFAULT,
    parameter int PEND_W        = 3,
    parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEFAULT
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       tick_1Hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    output logic       set_mode,
    output logic [1:0] field_sel,
    output logic       blink,
    output logic       inc_day,
    output logic       inc_month,
    output logic       inc_year
);

    localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);

    logic mode_rise_s, up_rise_s, tick_rise_s;

    rise_detect u_mode_rise (.clk(clk_100MHz), .reset(reset), .sig(btn_mode), .rise(mode_rise_s));
    rise_detect u_up_rise   (.clk(clk_100MHz), .reset(reset), .sig(btn_up),   .rise(up_rise_s));
    rise_detect u_tick_rise (.clk(clk_100MHz), .reset(reset), .sig(tick_1Hz), .rise(tick_rise_s));

    cal_state_e        state_r, state_s;
    logic [PEND_W-1:0] pend_r, pend_s;
    logic [IDLE_W-1:0] idle_r, idle_s;
    logic [2:0]        inc_r, inc_s;      // {year, month, day}
    logic              mode_req_r, mode_req_s;
    logic              blink_r, blink_s;
    logic              set_mode_r;
    logic              in_set_s, inc_active_s, up_cnt_s, done_s, quiet_s;
    logic              apply_s, timeout_s, change_s;

    // Next-state, queue, issue, idle and blink decisions
    always_comb begin
        inc_active_s = |inc_r;
        in_set_s     = (state_r != RUN);
        up_cnt_s     = up_rise_s & in_set_s;
        done_s       = inc_active_s & tick_rise_s;
        quiet_s      = (pend_r == {PEND_W{1'b0}}) & ~inc_active_s;
        apply_s      = mode_req_r & quiet_s & ~up_cnt_s;
        // A button rise in the same cycle restarts the idle window, so it also blocks the timeout.
        timeout_s    = in_set_s & (idle_r == IDLE_W'(TIMEOUT_TICKS)) & quiet_s
                       & ~mode_rise_s & ~up_rise_s;

        state_s = state_r;
        if (apply_s) begin
            state_s = next_field(state_r);
        end else if (timeout_s) begin
            state_s = RUN;
        end else begin
            state_s = state_r;
        end
        change_s = (state_s != state_r);

        mode_req_s = mode_req_r;
        if (apply_s) begin
            mode_req_s = 1'b0;
        end else if (mode_rise_s) begin
            mode_req_s = 1'b1;
        end else begin
            mode_req_s = mode_req_r;
        end

        pend_s = pend_r;
        case ({up_cnt_s, done_s})
            2'b10: begin
                if (pend_r != PEND_W'(MAX_PENDING)) begin
                    pend_s = pend_r + PEND_W'(1);
                end else begin
                    pend_s = pend_r;
                end
            end
            2'b01:   pend_s = pend_r - PEND_W'(1);
            default: pend_s = pend_r;
        endcase

        inc_s = inc_r;
        if (inc_active_s) begin
            if (done_s) begin
                inc_s = 3'b000;
            end else begin
                inc_s = inc_r;
            end
        end else if (pend_r != {PEND_W{1'b0}}) begin
            case (state_r)
                SET_DAY:   inc_s = 3'b001;
                SET_MONTH: inc_s = 3'b010;
                SET_YEAR:  inc_s = 3'b100;
                default:   inc_s = 3'b000;
            endcase
        end else begin
            inc_s = 3'b000;
        end

        idle_s = idle_r;
        if (change_s | mode_rise_s | up_rise_s) begin
            idle_s = {IDLE_W{1'b0}};
        end else if (in_set_s & tick_rise_s & (idle_r != IDLE_W'(TIMEOUT_TICKS))) begin
            idle_s = idle_r + IDLE_W'(1);
        end else begin
            idle_s = idle_r;
        end

        blink_s = blink_r;
        if (change_s | ~in_set_s) begin
            blink_s = 1'b0;
        end else if (tick_rise_s) begin
            blink_s = ~blink_r;
        end else begin
            blink_s = blink_r;
        end
    end

    // State and output registers
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_r    <= RUN;
            pend_r     <= {PEND_W{1'b0}};
            idle_r     <= {IDLE_W{1'b0}};
            inc_r      <= 3'b000;
            mode_req_r <= 1'b0;
            blink_r    <= 1'b0;
            set_mode_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            pend_r     <= pend_s;
            idle_r     <= idle_s;
            inc_r      <= inc_s;
            mode_req_r <= mode_req_s;
            blink_r    <= blink_s;
            set_mode_r <= (state_s != RUN);
        end
    end

    assign field_sel = state_r;
    assign set_mode  = set_mode_r;
    assign blink     = blink_r;
    assign inc_day   = inc_r[0];
    assign inc_month = inc_r[1];
    assign inc_year  = inc_r[2];

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Directed and randomized bench for calendar_set_ctrl against a per-clock behavioural model.
module tb_calendar_set_ctrl;

    localparam int MAXP    = 7;
    localparam int TIMEOUT = 10;
    localparam int TP      = 16;   // simulated tick_1Hz period in clk cycles

    logic       clk_100MHz = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1Hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       set_mode, blink, inc_day, inc_month, inc_year;
    logic [1:0] field_sel;

    calendar_set_ctrl dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .tick_1Hz(tick_1Hz),
        .btn_mode(btn_mode), .btn_up(btn_up), .set_mode(set_mode),
        .field_sel(field_sel), .blink(blink), .inc_day(inc_day),
        .inc_month(inc_month), .inc_year(inc_year)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit tick_en = 1'b0;

    // Reference model: field index 0..3, queued count, one outstanding request flag.
    int m_field, m_pend, m_idle;
    bit m_inc, m_modereq, m_blink, m_pm, m_pu, m_pt;

    int day_pulses, month_pulses, year_pulses;
    bit obs_d, obs_m, obs_y;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_field = 0; m_pend = 0; m_idle = 0;
        m_inc = 1'b0; m_modereq = 1'b0; m_blink = 1'b0;
        m_pm = 1'b0; m_pu = 1'b0; m_pt = 1'b0;
    endtask

    task automatic model_step();
        bit mr, ur, tr, in_set, upc, done, quiet, adv, tmo;
        int nf, np;
        mr = btn_mode && !m_pm;
        ur = btn_up && !m_pu;
        tr = tick_1Hz && !m_pt;
        in_set = (m_field != 0);
        upc = ur && in_set;
        done = m_inc && tr;
        quiet = (m_pend == 0) && !m_inc;
        adv = m_modereq && quiet && !upc;
        tmo = in_set && (m_idle >= TIMEOUT) && quiet && !mr && !ur;
        nf = adv ? (m_field + 1) % 4 : (tmo ? 0 : m_field);
        np = m_pend - (done ? 1 : 0);
        if (upc) np = (np + 1 > MAXP) ? MAXP : np + 1;
        if (m_inc) m_inc = !done;
        else m_inc = (m_pend > 0) && in_set;
        m_modereq = adv ? 1'b0 : (m_modereq || mr);
        if (nf != m_field || mr || ur) m_idle = 0;
        else if (in_set && tr && m_idle < TIMEOUT) m_idle++;
        if (nf != m_field || !in_set) m_blink = 1'b0;
        else if (tr) m_blink = !m_blink;
        m_pend = np;
        m_field = nf;
        m_pm = btn_mode; m_pu = btn_up; m_pt = tick_1Hz;
    endtask

    task automatic compare_outputs();
        int exp_inc;
        exp_inc = (m_inc && m_field != 0) ? (1 << (m_field - 1)) : 0;
        check_eq("field_sel", field_sel, m_field);
        check_eq("set_mode", set_mode, (m_field != 0) ? 1 : 0);
        check_eq("blink", blink, m_blink);
        check_eq("inc_vec", {inc_year, inc_month, inc_day}, exp_inc);
    endtask

    task automatic cycle();
        tick_1Hz = tick_en && ((cyc % TP) >= TP / 2);
        @(posedge clk_100MHz);
        if (reset) model_reset();
        else model_step();
        @(negedge clk_100MHz);
        compare_outputs();
        if (inc_day && !obs_d) day_pulses++;
        if (inc_month && !obs_m) month_pulses++;
        if (inc_year && !obs_y) year_pulses++;
        obs_d = inc_day; obs_m = inc_month; obs_y = inc_year;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; cycle(); cycle();
        btn_mode = 1'b0; cycle(); cycle();
    endtask

    task automatic press_up();
        btn_up = 1'b1; cycle(); cycle();
        btn_up = 1'b0; cycle(); cycle();
    endtask

    task automatic clear_pulses();
        day_pulses = 0; month_pulses = 0; year_pulses = 0;
    endtask

    initial begin
        int waited;
        model_reset();
        clear_pulses();
        obs_d = 1'b0; obs_m = 1'b0; obs_y = 1'b0;
        run(3);
        check_eq("rst_field", field_sel, 0);
        check_eq("rst_inc", {inc_year, inc_month, inc_day}, 0);
        reset = 1'b0;
        run(2);

        // Mode walk through all fields and back to RUN
        press_mode(); check_eq("walk_day", field_sel, 1);
        press_mode(); check_eq("walk_month", field_sel, 2);
        press_mode(); check_eq("walk_year", field_sel, 3);
        press_mode(); check_eq("walk_run", field_sel, 0);
        check_eq("walk_set_mode", set_mode, 0);

        // Three day increments queued within one second
        press_mode();
        clear_pulses();
        press_up(); press_up(); press_up();
        tick_en = 1'b1;
        run(80);
        check_eq("day_pulses", day_pulses, 3);
        check_eq("day_other", month_pulses + year_pulses, 0);

        // Mode change deferred until two month increments drain
        tick_en = 1'b0;
        press_mode();
        clear_pulses();
        press_up(); press_up();
        press_mode();
        check_eq("hold_month", field_sel, 2);
        tick_en = 1'b1;
        run(60);
        check_eq("after_drain", field_sel, 3);
        check_eq("month_pulses", month_pulses, 2);

        // Saturation at seven year increments
        tick_en = 1'b0;
        clear_pulses();
        for (int i = 0; i < 9; i++) press_up();
        tick_en = 1'b1;
        run(130);
        check_eq("year_pulses", year_pulses, 7);
        tick_en = 1'b0;
        press_mode();
        check_eq("year_to_run", field_sel, 0);

        // Idle timeout back to RUN, then an up press in RUN does nothing
        press_mode();
        tick_en = 1'b1;
        run(200);
        check_eq("timeout_field", field_sel, 0);
        check_eq("timeout_blink", blink, 0);
        clear_pulses();
        press_up();
        run(40);
        check_eq("run_up_ignored", day_pulses + month_pulses + year_pulses, 0);

        // Asynchronous reset while inc_day is high
        tick_en = 1'b0;
        press_mode();
        btn_up = 1'b1; cycle(); cycle();
        btn_up = 1'b0;
        waited = 0;
        while (!inc_day && waited < 20) begin cycle(); waited++; end
        check_eq("inc_day_seen", inc_day, 1);
        #2 reset = 1'b1;
        #1 check_eq("rst_drops_inc", inc_day, 0);
        model_reset();
        cycle(); cycle();
        reset = 1'b0;
        run(2);
        check_eq("post_rst_field", field_sel, 0);
        clear_pulses();
        tick_en = 1'b1;
        press_mode();
        run(40);
        check_eq("post_rst_pending", day_pulses, 0);

        // Randomized phases with differing button activity
        for (int blk = 0; blk < 4; blk++) begin
            int up_rate, mode_rate;
            up_rate = (blk == 0) ? 4 : (blk == 1) ? 10 : (blk == 2) ? 40 : 300;
            mode_rate = (blk == 3) ? 400 : 30;
            for (int i = 0; i < 1000; i++) begin
                if ($urandom_range(0, up_rate - 1) == 0) btn_up = ~btn_up;
                if ($urandom_range(0, mode_rate - 1) == 0) btn_mode = ~btn_mode;
                if ($urandom_range(0, 499) == 0) tick_en = ~tick_en;
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
